// File: rtl/rr_lane_merge.sv
// rr_lane_merge: fair round-robin merge of NUM_SEL word lanes into a single registered
// valid/ready output stream, tagging each word with the lane it came from.
module rr_lane_merge #(
   parameter int unsigned NUM_SEL   = 16,
   parameter int unsigned NUM_LOG   = 4,
   parameter int unsigned NUM_WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SEL-1:0]           in_valid,
   input  logic [NUM_WIDTH*NUM_SEL-1:0] in_data,
   output logic [NUM_SEL-1:0]           in_ready,
   output logic                         out_valid,
   output logic [NUM_WIDTH-1:0]         out_data,
   output logic [NUM_LOG-1:0]           out_lane,
   input  logic                         out_ready
);

   localparam logic StEmpty = 1'b0;
   localparam logic StFull  = 1'b1;
   localparam logic [NUM_LOG-1:0] LastLane = NUM_LOG'(NUM_SEL - 1);

   logic                 state_q, state_d;
   logic [NUM_LOG-1:0]   ptr_q, ptr_d;
   logic [NUM_WIDTH-1:0] data_q, data_d;
   logic [NUM_LOG-1:0]   lane_q, lane_d;

   logic                 any_req;
   logic                 can_load;
   logic                 load;
   logic [NUM_LOG-1:0]   grant;
   logic [NUM_LOG:0]     hi_pick;
   logic [NUM_LOG:0]     lo_pick;
   logic [NUM_SEL-1:0]   upper_req;
   logic [NUM_WIDTH-1:0] lane_word [NUM_SEL];

   // Returns {found, index} of the lowest set bit of vec.
   function automatic logic [NUM_LOG:0] first_set(input logic [NUM_SEL-1:0] vec);
      logic [NUM_SEL-1:0] tmp;
      logic [NUM_LOG:0]   res;
      tmp = vec;
      res = '0;
      for (int unsigned k = 0; k < NUM_SEL; k++) begin
         if (tmp[0] && !res[NUM_LOG]) begin
            res = {1'b1, NUM_LOG'(k)};
         end
         tmp = tmp >> 1;
      end
      return res;
   endfunction

   for (genvar i = 0; i < NUM_SEL; i++) begin : g_lane
      assign upper_req[i] = in_valid[i] & (NUM_LOG'(i) >= ptr_q);
      assign lane_word[i] = in_data[NUM_WIDTH*i +: NUM_WIDTH];
      assign in_ready[i]  = load & ~rst & (grant == NUM_LOG'(i));
   end

   // Rotated priority: requests at or above ptr win, otherwise wrap to the lowest request.
   assign hi_pick  = first_set(upper_req);
   assign lo_pick  = first_set(in_valid);
   assign grant    = hi_pick[NUM_LOG] ? hi_pick[NUM_LOG-1:0] : lo_pick[NUM_LOG-1:0];

   assign any_req  = |in_valid;
   assign can_load = (state_q == StEmpty) | out_ready;
   assign load     = can_load & any_req;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      lane_d  = lane_q;
      if (load) begin
         state_d = StFull;
         data_d  = lane_word[grant];
         lane_d  = grant;
         ptr_d   = (grant == LastLane) ? '0 : grant + 1'b1;
      end else if (state_q == StFull && out_ready) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         ptr_q   <= '0;
         data_q  <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         lane_q  <= lane_d;
      end
   end

   assign out_valid = state_q;
   assign out_data  = data_q;
   assign out_lane  = lane_q;

   ptr_in_range: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, ptr_q} < (NUM_LOG+1)'(NUM_SEL)));

endmodule
